slicer_rr_arbiter: RTL

Round-robin arbiter that shares one bit-slicer packet input among NREQ packet sources in the NoC router.
- Each source presents an 11-bit flit: addr = [3:0], data = [10:4].
- The block picks one winner per cycle and registers the winning flit into a single-entry output stage.
- The output stage drives the slicer's input channel with a valid/ready handshake.

---
 rtl/slicer_rr_arbiter.sv | 113 +++++++++++
 1 files changed

// File: rtl/slicer_rr_arbiter.sv
// Round-robin arbiter feeding one bit-slicer input from NREQ flit sources through a
// single-entry registered output stage. Define SLICER_ARB_STATS_EN for per-source grant counters.
module slicer_rr_arbiter #(
  parameter  int NREQ   = 4,
  parameter  int WIDTH  = 11,
  parameter  int ADDR_W = 4,
  localparam int SRC_W  = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  input  logic                  out_ready,
  output logic [SRC_W-1:0]      out_src,
  output logic [ADDR_W-1:0]     out_addr
`ifdef SLICER_ARB_STATS_EN
  ,
  input  logic                  stat_clr,
  input  logic [SRC_W-1:0]      stat_sel,
  output logic [15:0]           stat_count
`endif
);

  typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} stage_e;

  stage_e            state_r;
  logic [SRC_W-1:0]  last_r;
  logic [SRC_W-1:0]  cand_s;
  logic [SRC_W-1:0]  win_s;
  logic              found_s;
  logic              can_load_s;
  logic              accept_s;
  logic [WIDTH-1:0]  flit_s [NREQ];

  for (genvar g = 0; g < NREQ; g++) begin : g_flit
    assign flit_s[g] = req_data[g*WIDTH +: WIDTH];
  end

  assign out_valid  = (state_r == ST_FULL);
  assign out_addr   = out_data[ADDR_W-1:0];
  assign can_load_s = (state_r == ST_EMPTY) || out_ready;
  assign accept_s   = found_s && can_load_s && !reset;

  // Scan last+1, last+2, ... (mod NREQ); the first valid source wins.
  always_comb begin
    found_s = 1'b0;
    win_s   = {SRC_W{1'b0}};
    cand_s  = {SRC_W{1'b0}};
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = SRC_W'((int'(last_r) + k) % NREQ);
      if (!found_s && req_valid[cand_s]) begin
        found_s = 1'b1;
        win_s   = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant strobe: only the winner, only when the output stage can take a flit.
  always_comb begin
    req_ready        = {NREQ{1'b0}};
    req_ready[win_s] = accept_s;
  end

  // Output stage and priority pointer; a stalled stage holds data, source and pointer.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_EMPTY;
      out_data <= {WIDTH{1'b0}};
      out_src  <= {SRC_W{1'b0}};
      last_r   <= SRC_W'(NREQ - 1);
    end else if (accept_s) begin
      state_r  <= ST_FULL;
      out_data <= flit_s[win_s];
      out_src  <= win_s;
      last_r   <= win_s;
    end else if ((state_r == ST_FULL) && out_ready) begin
      state_r  <= ST_EMPTY;
    end else begin
      state_r  <= state_r;
    end
  end

`ifdef SLICER_ARB_STATS_EN
  logic [15:0] cnt_r [NREQ];

  // Saturating grant counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NREQ; i++) begin
      if (reset || stat_clr) begin
        cnt_r[i] <= 16'h0000;
      end else if (accept_s && (win_s == SRC_W'(i)) && (cnt_r[i] != 16'hFFFF)) begin
        cnt_r[i] <= cnt_r[i] + 16'd1;
      end else begin
        cnt_r[i] <= cnt_r[i];
      end
    end
  end

  // Counter readback for the selected source.
  always_comb begin
    stat_count = 16'h0000;
    for (int i = 0; i < NREQ; i++) begin
      stat_count = (stat_sel == SRC_W'(i)) ? cnt_r[i] : stat_count;
    end
  end
`endif

endmodule
